// File: rtl/imem_pkg.sv
// rtl/imem_pkg.sv - shared types, defaults and address helper for the instruction fetch controller
package imem_pkg;

    localparam int          NUM_INST_DEFAULT = 64;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_LOAD = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } fetch_state_e;

    // A byte address is usable for a word access when it is word-aligned and
    // falls inside the memory image.
    function automatic logic addr_ok(input logic [31:0] addr, input logic [31:0] mem_bytes);
        return (addr[1:0] == 2'b00) && (addr < mem_bytes);
    endfunction

endpackage

// File: rtl/imem_fetch_ctrl_if.sv
// rtl/imem_fetch_ctrl_if.sv - loader, memory and fetch-output bundle of the fetch controller
// Ports (slave = controller view):
//   loader   : ld_valid, ld_addr, ld_data, boot_done in; ld_ready out
//   memory   : mem_addr, mem_we, mem_wdata out; mem_rdata in (combinational read)
//   redirect : redirect_valid, redirect_pc in
//   fetch    : if_valid, if_pc, if_instr out; if_ready in
//   status   : fault, fetch_count out
interface imem_fetch_ctrl_if;

    logic        ld_valid;
    logic        ld_ready;
    logic [31:0] ld_addr;
    logic [31:0] ld_data;
    logic        boot_done;

    logic [31:0] mem_addr;
    logic        mem_we;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    logic        redirect_valid;
    logic [31:0] redirect_pc;

    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_pc;
    logic [31:0] if_instr;

    logic        fault;
    logic [31:0] fetch_count;

    modport slave (
        input  ld_valid, ld_addr, ld_data, boot_done,
        output ld_ready,
        output mem_addr, mem_we, mem_wdata,
        input  mem_rdata,
        input  redirect_valid, redirect_pc,
        output if_valid, if_pc, if_instr,
        input  if_ready,
        output fault, fetch_count
    );

    modport master (
        output ld_valid, ld_addr, ld_data, boot_done,
        input  ld_ready,
        input  mem_addr, mem_we, mem_wdata,
        output mem_rdata,
        output redirect_valid, redirect_pc,
        input  if_valid, if_pc, if_instr,
        output if_ready,
        input  fault, fetch_count
    );

endinterface

// File: rtl/if_out_reg.sv
// rtl/if_out_reg.sv - one-entry valid/ready output register with flush
// Ports: clk, rst (sync, active-high); flush drops the held entry;
//   in_valid/in_ready/in_pc/in_instr upstream; out_valid/out_ready/out_pc/out_instr downstream.
module if_out_reg (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_pc,
    input  logic [31:0] in_instr,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [31:0] out_instr
);

    logic        valid_q;
    logic [31:0] pc_q;
    logic [31:0] instr_q;

    // Can take a new entry when empty or when the held one leaves this cycle.
    assign in_ready  = !valid_q || out_ready;
    assign out_valid = valid_q;
    assign out_pc    = pc_q;
    assign out_instr = instr_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            pc_q    <= 32'h0;
            instr_q <= 32'h0;
        end else if (flush) begin
            valid_q <= 1'b0;
        end else if (in_valid && in_ready) begin
            valid_q <= 1'b1;
            pc_q    <= in_pc;
            instr_q <= in_instr;
        end else if (out_ready) begin
            valid_q <= 1'b0;
        end
    end

endmodule

// File: rtl/imem_fetch_ctrl.sv
// rtl/imem_fetch_ctrl.sv - boot loader front end and sequential instruction fetcher
// Ports: clk, rst (sync, active-high); bus (imem_fetch_ctrl_if.slave) carries loader,
//   memory, redirect, fetch-output and status signals.
// Params: NUM_INST memory depth in words, RESET_PC first fetch address after boot.
module imem_fetch_ctrl
    import imem_pkg::*;
#(
    parameter int          NUM_INST = NUM_INST_DEFAULT,
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic               clk,
    input  logic               rst,
    imem_fetch_ctrl_if.slave   bus
);

    localparam logic [31:0] MEM_BYTES = 32'(4 * NUM_INST);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  fetch_count_q;

    logic         ld_ready;
    logic         mem_we;
    logic [31:0]  mem_addr;
    logic [31:0]  mem_wdata;
    logic         fetch;
    logic         flush;

    logic         stage_in_ready;
    logic         stage_valid;
    logic [31:0]  stage_pc;
    logic [31:0]  stage_instr;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_LOAD;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ld_ready  = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = pc_q;
        mem_wdata = 32'h0;
        fetch     = 1'b0;
        flush     = 1'b0;
        unique case (state_q)
            ST_LOAD: begin
                // Every loader beat is accepted; only in-range aligned ones reach memory.
                ld_ready  = 1'b1;
                mem_addr  = bus.ld_addr;
                mem_wdata = bus.ld_data;
                mem_we    = bus.ld_valid && addr_ok(bus.ld_addr, MEM_BYTES);
                if (bus.boot_done) begin
                    state_d = ST_RUN;
                    pc_d    = RESET_PC;
                end
            end
            ST_RUN: begin
                if (bus.redirect_valid) begin
                    // Redirect wins over fetch and stall; an entry handshaking
                    // this cycle still leaves normally before the flush lands.
                    flush = 1'b1;
                    pc_d  = bus.redirect_pc;
                end else if (stage_in_ready) begin
                    if (!addr_ok(pc_q, MEM_BYTES)) begin
                        state_d = ST_HALT;
                        flush   = 1'b1;
                    end else begin
                        fetch = 1'b1;
                        pc_d  = pc_q + 32'd4;
                    end
                end
            end
            ST_HALT: begin
                flush = 1'b1;
            end
            default: begin
                state_d = ST_LOAD;
            end
        endcase
    end

    if_out_reg u_out (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (fetch),
        .in_ready  (stage_in_ready),
        .in_pc     (pc_q),
        .in_instr  (bus.mem_rdata),
        .out_valid (stage_valid),
        .out_ready (bus.if_ready),
        .out_pc    (stage_pc),
        .out_instr (stage_instr)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_count_q <= 32'h0;
        end else if (stage_valid && bus.if_ready) begin
            fetch_count_q <= fetch_count_q + 32'd1;
        end
    end

    assign bus.ld_ready    = ld_ready;
    assign bus.mem_addr    = mem_addr;
    assign bus.mem_we      = mem_we;
    assign bus.mem_wdata   = mem_wdata;
    assign bus.if_valid    = stage_valid;
    assign bus.if_pc       = stage_pc;
    assign bus.if_instr    = stage_instr;
    assign bus.fault       = (state_q == ST_HALT);
    assign bus.fetch_count = fetch_count_q;

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// tb/tb_imem_fetch_ctrl.sv - scoreboard testbench for imem_fetch_ctrl
module tb_imem_fetch_ctrl;
    import imem_pkg::*;

    localparam int NI = 64;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    imem_fetch_ctrl_if bus ();

    imem_fetch_ctrl #(.NUM_INST(NI), .RESET_PC(32'h0)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [31:0] mem [0:NI-1];
    assign bus.mem_rdata = (bus.mem_addr < 32'(4 * NI)) ? mem[bus.mem_addr[7:2]] : 32'h0;
    always @(posedge clk) begin
        if (bus.mem_we && bus.mem_addr < 32'(4 * NI)) mem[bus.mem_addr[7:2]] <= bus.mem_wdata;
    end

    int n_checks = 0;
    int n_pass   = 0;
    int n_hs     = 0;
    logic [63:0] sb [$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    endtask

    function automatic logic [31:0] word_of(input int i);
        if (i == 0) return 32'h0000_0033;
        if (i == 1) return 32'h4000_0033;
        return 32'h1000_0000 | 32'(i * 32'h11);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] pc);
        sb.push_back({pc, word_of(int'(pc >> 2))});
    endtask

    // Scoreboard consumer: every accepted handshake pops one expected entry.
    always @(negedge clk) begin
        if (!rst && bus.if_valid && bus.if_ready) begin
            n_hs++;
            if (sb.size() == 0) begin
                check("sb_unexpected", bus.if_pc, 32'hFFFF_FFFF);
            end else begin
                logic [63:0] e;
                e = sb.pop_front();
                check("sb_pc", bus.if_pc, e[63:32]);
                check("sb_instr", bus.if_instr, e[31:0]);
            end
        end
    end

    initial begin
        for (int i = 0; i < NI; i++) mem[i] = 32'h0;
        bus.ld_valid = 0; bus.ld_addr = 0; bus.ld_data = 0; bus.boot_done = 0;
        bus.redirect_valid = 0; bus.redirect_pc = 0; bus.if_ready = 0;

        tick(); tick();
        check("rst_state", 32'(dut.state_q), 32'(ST_LOAD));
        check("rst_pc", dut.pc_q, 32'h0);
        check("rst_if_valid", 32'(bus.if_valid), 0);
        check("rst_fault", 32'(bus.fault), 0);
        check("rst_count", bus.fetch_count, 0);
        check("rst_if_pc", bus.if_pc, 0);
        check("rst_if_instr", bus.if_instr, 0);
        rst = 0;
        check("load_ld_ready", 32'(bus.ld_ready), 1);
        check("load_idle_we", 32'(bus.mem_we), 0);

        for (int i = 0; i < 15; i++) begin
            bus.ld_valid = 1; bus.ld_addr = 32'(4 * i); bus.ld_data = word_of(i);
            #1;
            if (i == 3) begin
                check("ld_we", 32'(bus.mem_we), 1);
                check("ld_mem_addr", bus.mem_addr, 32'hC);
                check("ld_mem_wdata", bus.mem_wdata, word_of(3));
            end
            tick();
        end
        bus.ld_addr = 32'h2; bus.ld_data = 32'hBAD0_0002; #1;
        check("ld_misalign_ready", 32'(bus.ld_ready), 1);
        check("ld_misalign_we", 32'(bus.mem_we), 0);
        tick();
        bus.ld_addr = 32'(4 * NI); bus.ld_data = 32'hBAD0_0100; #1;
        check("ld_oor_ready", 32'(bus.ld_ready), 1);
        check("ld_oor_we", 32'(bus.mem_we), 0);
        tick();
        bus.ld_addr = 32'h3C; bus.ld_data = word_of(15); bus.boot_done = 1;
        tick();
        bus.ld_valid = 0; bus.boot_done = 0;
        check("mem0_intact", mem[0], word_of(0));
        check("boot_write_done", mem[15], word_of(15));
        check("boot_state", 32'(dut.state_q), 32'(ST_RUN));
        check("boot_lat1_valid", 32'(bus.if_valid), 0);
        check("run_ld_ready", 32'(bus.ld_ready), 0);
        tick();
        check("boot_lat2_valid", 32'(bus.if_valid), 1);
        check("boot_first_pc", bus.if_pc, 32'h0);
        check("boot_first_instr", bus.if_instr, word_of(0));

        for (int c = 0; c < 3; c++) begin
            tick();
            check("stall_valid", 32'(bus.if_valid), 1);
            check("stall_pc", bus.if_pc, 32'h0);
            check("stall_instr", bus.if_instr, word_of(0));
            check("stall_pc_reg", dut.pc_q, 32'h4);
        end

        push(32'h0); push(32'h4);
        bus.if_ready = 1;
        tick(); tick();
        bus.if_ready = 0;
        check("count_two", bus.fetch_count, 32'd2);
        check("held_pc", bus.if_pc, 32'h8);

        bus.redirect_valid = 1; bus.redirect_pc = 32'h24;
        tick();
        bus.redirect_valid = 0;
        check("redir_flush", 32'(bus.if_valid), 0);
        tick();
        check("redir_valid", 32'(bus.if_valid), 1);
        check("redir_pc", bus.if_pc, 32'h24);
        check("redir_instr", bus.if_instr, word_of(9));

        for (int k = 0; k < 5; k++) push(32'h24 + 32'(4 * k));
        bus.if_ready = 1;
        repeat (5) tick();

        push(32'h38);
        bus.redirect_valid = 1; bus.redirect_pc = 32'h8;
        tick();
        bus.redirect_valid = 0;
        check("redir_hs_flush", 32'(bus.if_valid), 0);
        push(32'h8); push(32'hC);
        repeat (3) tick();
        bus.if_ready = 0;
        check("count_ten", bus.fetch_count, 32'd10);
        check("hs_seen", 32'(n_hs), 32'd10);
        check("held_pc2", bus.if_pc, 32'h10);

        force dut.fetch_count_q = 32'hFFFF_FFFF;
        #1;
        release dut.fetch_count_q;
        check("count_preload", bus.fetch_count, 32'hFFFF_FFFF);
        push(32'h10);
        bus.if_ready = 1;
        tick();
        bus.if_ready = 0;
        check("count_wrap", bus.fetch_count, 32'h0);

        bus.redirect_valid = 1; bus.redirect_pc = 32'h102;
        tick();
        bus.redirect_valid = 0;
        check("bad_redir_valid", 32'(bus.if_valid), 0);
        check("bad_redir_state", 32'(dut.state_q), 32'(ST_RUN));
        tick();
        check("halt_state", 32'(dut.state_q), 32'(ST_HALT));
        check("halt_fault", 32'(bus.fault), 1);
        check("halt_valid", 32'(bus.if_valid), 0);
        bus.ld_valid = 1; bus.ld_addr = 32'h0; bus.ld_data = 32'hFFFF_FFFF;
        bus.boot_done = 1; bus.if_ready = 1;
        bus.redirect_valid = 1; bus.redirect_pc = 32'h0;
        #1;
        check("halt_ld_ready", 32'(bus.ld_ready), 0);
        check("halt_we", 32'(bus.mem_we), 0);
        repeat (3) tick();
        check("halt_sticky", 32'(bus.fault), 1);
        check("halt_still_valid", 32'(bus.if_valid), 0);
        check("halt_mem0", mem[0], word_of(0));
        bus.ld_valid = 0; bus.boot_done = 0; bus.if_ready = 0; bus.redirect_valid = 0;

        rst = 1;
        tick();
        rst = 0;
        check("post_rst_state", 32'(dut.state_q), 32'(ST_LOAD));
        check("post_rst_fault", 32'(bus.fault), 0);
        check("post_rst_count", bus.fetch_count, 0);

        bus.boot_done = 1;
        tick();
        bus.boot_done = 0;
        tick();
        check("reboot_valid", 32'(bus.if_valid), 1);
        check("reboot_instr", bus.if_instr, word_of(0));
        rst = 1;
        tick();
        check("abort_valid", 32'(bus.if_valid), 0);
        check("abort_pc", bus.if_pc, 0);
        check("abort_instr", bus.if_instr, 0);
        check("abort_mem1", mem[1], word_of(1));
        rst = 0;
        tick();

        check("sb_empty", 32'(sb.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
